// File: rtl/dp_pkg.sv
// ---------------------------------------------------------------------------
// dp_pkg
// Shared definitions for the data-processing issue path. It holds the
// controller state encoding, the ALU op-unit index constants, the packed
// N/Z/C flag type and the default op-unit count.
// ---------------------------------------------------------------------------
package dp_pkg;

    // Default number of op units. The op-unit index is 4 bits wide.
    localparam int DP_NUM_OPS = 16;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WB    = 3'd4
    } state_e;

    // Op-unit indices, in classic data-processing opcode order
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_OR  = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    // Condition flags as committed by writeback
    typedef struct packed {
        logic n;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/dp_flag_reg.sv
// ---------------------------------------------------------------------------
// dp_flag_reg
// N/Z/C condition-flag register with write enable. It is shared by the issue
// controller and the status/branch logic, so it lives in its own module.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset, clears all flags
//   we_i     - load flags_i on the next rising edge
//   flags_i  - new flag values
//   flags_o  - committed flag values
// ---------------------------------------------------------------------------
module dp_flag_reg
    import dp_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   we_i,
    input  flags_t flags_i,
    output flags_t flags_o
);

    flags_t flags_d;
    flags_t flags_q;

    // Hold the flags unless a commit is requested
    always_comb begin
        flags_d = flags_q;
        if (we_i) begin
            flags_d = flags_i;
        end
    end

    // Flag storage, cleared asynchronously so an aborted operation never
    // leaves stale flags behind
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;

endmodule

// File: rtl/dp_issue_ctrl.sv
// ---------------------------------------------------------------------------
// dp_issue_ctrl
// Single-issue controller that sequences one data-processing instruction at
// a time. It accepts a decoded instruction and reads Rn/Rm from a synchronous
// register file. It then pulses the enable of one op unit and waits for its
// done, with a timeout. Finally it writes Rd back and optionally commits
// N/Z/C.
//
// Ports:
//   clk_i, rst_ni              - clock and asynchronous active-low reset
//   in_*                       - decoded instruction, valid/ready handshake
//   rf_raddr_*_o, rf_rdata_*_i - register-file read ports (1-cycle latency)
//   op_en_o                    - one-hot op-unit enable pulse
//   op_rn/rm/imm*/s/stype_o    - operands presented to the op units
//   op_*_in_o                  - committed flags fed to the op units
//   op_done_i, op_rd_i, op_*_i - result and flags from the selected unit
//   rf_we/waddr/wdata_o        - register-file write port
//   flag_n/z/c_o               - committed flags
//   busy_o                     - controller not idle
//   err_illegal_o              - pulse: opcode has no op unit
//   err_timeout_o              - pulse: op unit did not finish in time
// ---------------------------------------------------------------------------
module dp_issue_ctrl
    import dp_pkg::*;
#(
    parameter int NUM_OPS = DP_NUM_OPS,
    parameter int TIMEOUT = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [3:0]         in_opcode_i,
    input  logic [3:0]         in_rd_i,
    input  logic [3:0]         in_rn_i,
    input  logic [3:0]         in_rm_i,
    input  logic               in_imm_i,
    input  logic               in_s_i,
    input  logic [11:0]        in_imm_operand_i,
    input  logic [4:0]         in_imm_shift_i,
    input  logic [1:0]         in_stype_i,
    output logic [3:0]         rf_raddr_a_o,
    output logic [3:0]         rf_raddr_b_o,
    input  logic [31:0]        rf_rdata_a_i,
    input  logic [31:0]        rf_rdata_b_i,
    output logic [NUM_OPS-1:0] op_en_o,
    output logic [31:0]        op_rn_o,
    output logic [31:0]        op_rm_o,
    output logic               op_imm_o,
    output logic               op_s_o,
    output logic [11:0]        op_imm_operand_o,
    output logic [4:0]         op_imm_shift_o,
    output logic [1:0]         op_stype_o,
    output logic               op_carry_in_o,
    output logic               op_zero_in_o,
    output logic               op_neg_in_o,
    input  logic               op_done_i,
    input  logic [31:0]        op_rd_i,
    input  logic               op_carry_i,
    input  logic               op_zero_i,
    input  logic               op_neg_i,
    output logic               rf_we_o,
    output logic [3:0]         rf_waddr_o,
    output logic [31:0]        rf_wdata_o,
    output logic               flag_n_o,
    output logic               flag_z_o,
    output logic               flag_c_o,
    output logic               busy_o,
    output logic               err_illegal_o,
    output logic               err_timeout_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [3:0]         opcode_q;
    logic [3:0]         rd_q;
    logic               immSel_q;
    logic               setFlags_q;
    logic [11:0]        immOperand_q;
    logic [4:0]         immShift_q;
    logic [1:0]         stype_q;
    logic [3:0]         raddrA_q;
    logic [3:0]         raddrB_q;
    logic [NUM_OPS-1:0] opEn_q;
    logic [31:0]        opRn_q;
    logic [31:0]        opRm_q;
    logic               opImm_q;
    logic               opS_q;
    logic [11:0]        opImmOperand_q;
    logic [4:0]         opImmShift_q;
    logic [1:0]         opStype_q;
    logic [CNT_W-1:0]   waitCnt_q;
    flags_t             capFlags_q;
    logic               rfWe_q;
    logic [3:0]         rfWaddr_q;
    logic [31:0]        rfWdata_q;
    logic               errIllegal_q;
    logic               errTimeout_q;

    logic               flagWe;
    flags_t             flagsCommitted;

    // Sequencing FSM with all control and data outputs registered. The
    // pulse outputs default low each cycle and are raised only by the
    // transition that owns them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            opcode_q       <= '0;
            rd_q           <= '0;
            immSel_q       <= 1'b0;
            setFlags_q     <= 1'b0;
            immOperand_q   <= '0;
            immShift_q     <= '0;
            stype_q        <= '0;
            raddrA_q       <= '0;
            raddrB_q       <= '0;
            opEn_q         <= '0;
            opRn_q         <= '0;
            opRm_q         <= '0;
            opImm_q        <= 1'b0;
            opS_q          <= 1'b0;
            opImmOperand_q <= '0;
            opImmShift_q   <= '0;
            opStype_q      <= '0;
            waitCnt_q      <= '0;
            capFlags_q     <= '0;
            rfWe_q         <= 1'b0;
            rfWaddr_q      <= '0;
            rfWdata_q      <= '0;
            errIllegal_q   <= 1'b0;
            errTimeout_q   <= 1'b0;
        end else begin
            opEn_q       <= '0;
            rfWe_q       <= 1'b0;
            errIllegal_q <= 1'b0;
            errTimeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        opcode_q     <= in_opcode_i;
                        rd_q         <= in_rd_i;
                        immSel_q     <= in_imm_i;
                        setFlags_q   <= in_s_i;
                        immOperand_q <= in_imm_operand_i;
                        immShift_q   <= in_imm_shift_i;
                        stype_q      <= in_stype_i;
                        raddrA_q     <= in_rn_i;
                        raddrB_q     <= in_rm_i;
                        // Opcodes with no op unit are rejected here and never leave IDLE
                        if (int'(in_opcode_i) >= NUM_OPS) begin
                            errIllegal_q <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    // Raise the enable so it is high exactly during ISSUE
                    opEn_q         <= NUM_OPS'(1) << opcode_q;
                    opImm_q        <= immSel_q;
                    opS_q          <= setFlags_q;
                    opImmOperand_q <= immOperand_q;
                    opImmShift_q   <= immShift_q;
                    opStype_q      <= stype_q;
                    state_q        <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    opRn_q    <= rf_rdata_a_i;
                    opRm_q    <= rf_rdata_b_i;
                    waitCnt_q <= '0;
                    state_q   <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done takes priority over a timeout that lands on the same cycle
                    if (op_done_i) begin
                        capFlags_q <= '{n: op_neg_i, z: op_zero_i, c: op_carry_i};
                        rfWe_q     <= 1'b1;
                        rfWaddr_q  <= rd_q;
                        rfWdata_q  <= op_rd_i;
                        state_q    <= ST_WB;
                    end else if (waitCnt_q == CNT_LAST) begin
                        errTimeout_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end else begin
                        waitCnt_q <= waitCnt_q + CNT_W'(1);
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Flags are committed at the end of the writeback cycle only when the
    // instruction asked for it
    assign flagWe = (state_q == ST_WB) && setFlags_q;

    dp_flag_reg u_flag_reg (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (flagWe),
        .flags_i (capFlags_q),
        .flags_o (flagsCommitted)
    );

    // During ISSUE the register-file data is only just arriving, so it is
    // passed straight through alongside the enable pulse. After that the
    // captured copy holds it until the next ISSUE.
    assign op_rn_o = (state_q == ST_ISSUE) ? rf_rdata_a_i : opRn_q;
    assign op_rm_o = (state_q == ST_ISSUE) ? rf_rdata_b_i : opRm_q;

    assign in_ready_o       = (state_q == ST_IDLE);
    assign busy_o           = (state_q != ST_IDLE);
    assign rf_raddr_a_o     = raddrA_q;
    assign rf_raddr_b_o     = raddrB_q;
    assign op_en_o          = opEn_q;
    assign op_imm_o         = opImm_q;
    assign op_s_o           = opS_q;
    assign op_imm_operand_o = opImmOperand_q;
    assign op_imm_shift_o   = opImmShift_q;
    assign op_stype_o       = opStype_q;
    assign op_carry_in_o    = flagsCommitted.c;
    assign op_zero_in_o     = flagsCommitted.z;
    assign op_neg_in_o      = flagsCommitted.n;
    assign rf_we_o          = rfWe_q;
    assign rf_waddr_o       = rfWaddr_q;
    assign rf_wdata_o       = rfWdata_q;
    assign flag_n_o         = flagsCommitted.n;
    assign flag_z_o         = flagsCommitted.z;
    assign flag_c_o         = flagsCommitted.c;
    assign err_illegal_o    = errIllegal_q;
    assign err_timeout_o    = errTimeout_q;

endmodule

// File: doc/dp_issue_ctrl.md
# dp_issue_ctrl

Single-issue controller that sequences one data-processing instruction at a time through the ALU operation units (op_or and its siblings). It accepts a decoded instruction over a valid/ready handshake and reads Rn/Rm from the register file. It pulses the enable of exactly one op unit, waits for completion with a timeout, then writes Rd back and commits the N/Z/C flags. It sits between the decode stage and the register file / op-unit bank.

## Interface
- NUM_OPS, 16, number of op units; width of one-hot `op_en`
- TIMEOUT, 32, max WAIT cycles before abort (≥2)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept
- in_opcode  in  4  op-unit index
- in_rd, in_rn, in_rm  in  4 each  register addresses
- in_imm, in_s  in  1 each  immediate select, set-flags
- in_imm_operand  in  12;  in_imm_shift  in  5;  in_stype  in  2
- rf_raddr_a, rf_raddr_b  out  4 each  read addresses (synchronous RF, 1-cycle latency)
- rf_rdata_a, rf_rdata_b  in  32 each
- op_en  out  NUM_OPS  one-hot enable pulse
- op_rn, op_rm  out  32 each;  op_imm, op_s  out  1;  op_imm_operand  out  12;  op_imm_shift  out  5;  op_stype  out  2
- op_carry_in, op_zero_in, op_neg_in  out  1 each  current committed flags
- op_done  in  1  selected unit result valid
- op_rd  in  32;  op_carry, op_zero, op_neg  in  1 each
- rf_we  out  1;  rf_waddr  out  4;  rf_wdata  out  32
- flag_n, flag_z, flag_c  out  1 each  committed flags
- busy  out  1  state ≠ IDLE
- err_illegal, err_timeout  out  1 each  single-cycle pulses

## Operation
- States: IDLE, READ, ISSUE, WAIT, WB.
- IDLE: in_ready=1. On in_valid, latch all in_* fields.
  - If in_opcode ≥ NUM_OPS, pulse err_illegal next cycle and stay IDLE.
  - Otherwise go to READ.
- READ: drive rf_raddr_a=rn, rf_raddr_b=rm. Next state ISSUE.
- ISSUE: capture rf_rdata_a/b into op_rn/op_rm, drive op_en[opcode]=1 for exactly one cycle, clear the timeout counter. Next state WAIT.
- WAIT: op_en=0; increment the counter each cycle.
  - op_done=1: capture op_rd and the three flags, go to WB.
  - Counter reaches TIMEOUT-1 without op_done: pulse err_timeout, go to IDLE with no writeback and no flag change.
  - op_done in the same cycle as the timeout: op_done wins.
- WB: rf_we=1, rf_waddr=rd, rf_wdata=captured result for one cycle.
  - If the latched S=1, update flag_n/z/c from the captured flags. If S=0, flags hold.
  - Next state IDLE.
- op_* operand outputs hold their latched values from ISSUE until the next ISSUE.
- op_*_in always reflect the committed flags.
- Writes to rd=15 are ordinary writes; the controller has no PC handling.
- in_valid outside IDLE is ignored. Decode must hold in_valid until in_ready.

## Timing
- Reset (rst=0, asynchronous): state IDLE. op_en, rf_we, err_* = 0. Flags = 0. All data outputs = 0. in_ready=1 from the first cycle after release.
- Accept at edge T → READ T+1 → ISSUE T+2 (op_en high) → WAIT from T+3.
- If op_done is first seen in WAIT at cycle W → WB at W+1 (rf_we high) → IDLE at W+2.
- Minimum issue-to-issue: 5 cycles.
- Flags committed in WB are visible on flag_* and op_*_in the cycle after WB.
- Reset asserted mid-operation aborts immediately: no partial rf_we or flag update, pending instruction discarded.

## Structure
- Shared package `dp_pkg`:
  - state enum (IDLE, READ, ISSUE, WAIT, WB)
  - opcode constants (OP_AND, OP_OR, …)
  - packed flag type {n, z, c}
  - NUM_OPS default
- One sub-module, `dp_flag_reg`: the N/Z/C register with write-enable and async active-low reset, reused by the status/branch logic.

## Test plan
- Reset, then issue OR opcode, rn=1, rm=2, S=1. Stub unit returns 0x0000_0000 with done in the first WAIT cycle → rf_we at T+4 with waddr=rd, wdata=0; flag_z=1 from T+5; op_en one-hot on exactly one cycle (T+2).
- Same instruction with S=0 and stub result 0x8000_0000 → write occurs, flags unchanged.
- Stub never asserts done, TIMEOUT=32 → err_timeout pulses once, no rf_we, back to IDLE, in_ready=1.
- in_opcode=NUM_OPS → err_illegal pulse, op_en stays 0, in_ready never drops.
- op_done on the same cycle the counter hits TIMEOUT-1 → WB happens, no err_timeout.
- Reset asserted during WAIT → all outputs to reset values asynchronously. A subsequent instruction completes normally with the flags starting from 0.
